// File: rtl/transaccion_pkg.sv
// Shared definitions for the transaction-layer FIFOs: default geometry,
// threshold reset values and each FIFO's bit position in the status vectors.
package transaccion_pkg;

  localparam int DATA_W_DEF = 6;
  localparam int ADDR_W_DEF = 3;

  localparam int UMBRAL_BAJO_RST = 1;

  // Almost-full resets to one below the depth implied by addr_w.
  function automatic int umbral_alto_rst(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

  // Bit positions inside Fifo_empties[4:0] / Fifo_errors[4:0].
  localparam int FIFO_MAIN_BIT = 0;
  localparam int FIFO_VC0_BIT  = 1;
  localparam int FIFO_VC1_BIT  = 2;
  localparam int FIFO_D0_BIT   = 3;
  localparam int FIFO_D1_BIT   = 4;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register file: synchronous write, synchronous read with a
// read register that holds its value when no read is requested.
module fifo_mem
  import transaccion_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // A same-edge read of the slot being written returns the old word.
  always_ff @(posedge clk) begin
    if (reset)   rd_data <= '0;
    else if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fifo_umbrales.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds and
// a sticky overflow/underflow error flag.
module fifo_umbrales
  import transaccion_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [ADDR_W:0]   umbral_alto,
  input  logic [ADDR_W:0]   umbral_bajo,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  input  logic              error_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              error
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ALTO_RST   = (ADDR_W+1)'(umbral_alto_rst(ADDR_W));
  localparam logic [ADDR_W:0] BAJO_RST   = (ADDR_W+1)'(UMBRAL_BAJO_RST);
  localparam logic [ADDR_W:0] ONE        = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_q, alto_q, bajo_q;
  logic              push_ok, pop_ok, overflow, underflow;

  // Flags derive only from registered occupancy and thresholds.
  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= alto_q);
  assign almost_empty = (count_q <= bajo_q);

  // Handshake: there is no ready. Each accepted pop yields valid_out=1 for
  // exactly one cycle after the edge, with the word on data_out; the
  // consumer must take it in that cycle. data_out holds between reads.
  assign pop_ok    = pop && !empty;
  assign push_ok   = push && (!full || pop);
  assign overflow  = push && full && !pop;
  assign underflow = pop && empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= pop_ok;
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + ONE;
        2'b01:   count_q <= count_q - ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // A new error wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset)                      error <= 1'b0;
    else if (overflow || underflow) error <= 1'b1;
    else if (error_clr)             error <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alto_q <= ALTO_RST;
      bajo_q <= BAJO_RST;
    end else if (init) begin
      alto_q <= umbral_alto;
      bajo_q <= umbral_bajo;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we      (push_ok),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .re      (pop_ok),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_fifo_umbrales.sv
// Self-checking bench for fifo_umbrales: reference model plus an expected-data
// queue, directed scenarios followed by random push/pop traffic.
module tb_fifo_umbrales;

  localparam int DATA_W = 6;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              init = 1'b0;
  logic [ADDR_W:0]   umbral_alto = '0;
  logic [ADDR_W:0]   umbral_bajo = '0;
  logic              push = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              pop = 1'b0;
  logic              error_clr = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [ADDR_W:0]   count;
  logic              empty, full, almost_full, almost_empty, error;

  fifo_umbrales #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .umbral_alto  (umbral_alto),
    .umbral_bajo  (umbral_bajo),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .error_clr    (error_clr),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard state
  logic [DATA_W-1:0] exp_q[$];
  int                m_count;
  int                m_alto, m_bajo;
  logic              m_err;
  logic [DATA_W-1:0] m_dout;
  int                n_cmp = 0;
  int                n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input logic exp_valid);
    check("valid_out", 32'(valid_out), 32'(exp_valid));
    check("data_out", 32'(data_out), 32'(m_dout));
    check("count", 32'(count), 32'(m_count));
    check("empty", 32'(empty), 32'(m_count == 0));
    check("full", 32'(full), 32'(m_count == DEPTH));
    check("almost_full", 32'(almost_full), 32'(m_count >= m_alto));
    check("almost_empty", 32'(almost_empty), 32'(m_count <= m_bajo));
    check("error", 32'(error), 32'(m_err));
  endtask

  // One clock with the currently driven inputs; model updated before the edge.
  task automatic step();
    logic pop_ok, push_ok, ovf, udf;
    pop_ok  = pop && (m_count != 0);
    push_ok = push && ((m_count != DEPTH) || pop);
    ovf     = push && (m_count == DEPTH) && !pop;
    udf     = pop && (m_count == 0);
    if (pop_ok) m_dout = exp_q.pop_front();
    if (push_ok) exp_q.push_back(data_in);
    m_count = m_count + int'(push_ok) - int'(pop_ok);
    if (ovf || udf) m_err = 1'b1;
    else if (error_clr) m_err = 1'b0;
    if (init) begin
      m_alto = int'(umbral_alto);
      m_bajo = int'(umbral_bajo);
    end
    @(posedge clk);
    #1;
    check_outputs(pop_ok);
  endtask

  // Driver tasks
  task automatic drive(input logic p, input logic [DATA_W-1:0] d, input logic q, input logic clr);
    push = p; data_in = d; pop = q; error_clr = clr;
    step();
    push = 1'b0; pop = 1'b0; error_clr = 1'b0;
  endtask

  task automatic load_thresholds(input int alto, input int bajo);
    init = 1'b1; umbral_alto = (ADDR_W+1)'(alto); umbral_bajo = (ADDR_W+1)'(bajo);
    step();
    init = 1'b0;
  endtask

  // Reset with busy inputs to show that reset overrides everything.
  task automatic do_reset();
    reset = 1'b1; push = 1'b1; pop = 1'b1; data_in = '1; init = 1'b1;
    umbral_alto = 4'd2; umbral_bajo = 4'd5; error_clr = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    m_count = 0; m_err = 1'b0; m_dout = '0; m_alto = DEPTH - 1; m_bajo = 1;
    reset = 1'b0; push = 1'b0; pop = 1'b0; init = 1'b0;
    check_outputs(1'b0);
    check("alto_q", 32'(dut.alto_q), 32'(DEPTH - 1));
    check("bajo_q", 32'(dut.bajo_q), 32'd1);
  endtask

  initial begin
    m_count = 0; m_err = 1'b0; m_dout = '0; m_alto = DEPTH - 1; m_bajo = 1;
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b0, 1'b0);

    // Thresholds alto=6 bajo=2, then fill 0x01..0x08
    load_thresholds(6, 2);
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b1, DATA_W'(i), 1'b0, 1'b0);
      if (i == 3) check("ae_drop_at_3", 32'(almost_empty), 32'd0);
      if (i == 5) check("af_low_at_5", 32'(almost_full), 32'd0);
      if (i == 6) check("af_rise_at_6", 32'(almost_full), 32'd1);
    end
    check("full_at_8", 32'(full), 32'd1);
    check("no_err_fill", 32'(error), 32'd0);

    // Overflow, then drain: dropped word 0x3F must never show up
    drive(1'b1, 6'h3F, 1'b0, 1'b0);
    check("ovf_err", 32'(error), 32'd1);
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      check("drain_order", 32'(data_out), 32'(i));
    end
    check("empty_after_drain", 32'(empty), 32'd1);

    // Clear with no new error
    drive(1'b0, '0, 1'b0, 1'b1);
    check("clr_falls", 32'(error), 32'd0);

    // Refill (wrapped pointers), then full + push + pop
    for (int i = 0; i < DEPTH; i++) drive(1'b1, DATA_W'($urandom_range(0, 62)), 1'b0, 1'b0);
    drive(1'b1, 6'h09, 1'b1, 1'b0);
    check("full_pushpop_cnt", 32'(count), 32'd8);
    check("full_pushpop_err", 32'(error), 32'd0);
    for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, 1'b1, 1'b0);
    check("last_is_09", 32'(data_out), 32'h09);

    // Empty + push + pop: push accepted, pop underflows
    drive(1'b1, 6'h15, 1'b1, 1'b0);
    check("empty_pushpop_cnt", 32'(count), 32'd1);
    check("empty_pushpop_err", 32'(error), 32'd1);
    check("empty_pushpop_vld", 32'(valid_out), 32'd0);
    drive(1'b0, '0, 1'b1, 1'b0);

    // Clear together with a new underflow: set wins
    drive(1'b0, '0, 1'b1, 1'b1);
    check("clr_vs_set", 32'(error), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b1);

    // Mid-operation reset at count=5 with non-default thresholds
    load_thresholds(3, 0);
    for (int i = 0; i < 5; i++) drive(1'b1, DATA_W'(i + 32), 1'b0, 1'b0);
    check("pre_reset_cnt", 32'(count), 32'd5);
    do_reset();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 40) == 0) load_thresholds($urandom_range(0, 9), $urandom_range(0, 9));
      else drive(1'($urandom_range(0, 1)), DATA_W'($urandom_range(0, 63)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
